// File: rtl/encoder_8x3.sv
// 8-to-3 priority encoder with a valid flag in b[3]; selectable MSB/LSB priority
// and an optional one-cycle output register.
module encoder_8x3 #(
  parameter int MSB_PRIORITY = 1,
  parameter int REG_OUT      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       en,
  output logic [3:0] b
);

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  // Highest set bit wins: later (higher) indices overwrite earlier ones.
  function automatic logic [IDX_W-1:0] enc_msb(input logic [DATA_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] enc_lsb(input logic [DATA_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

  logic             w_vld_p0;
  logic [IDX_W-1:0] w_idx_p0;
  logic [3:0]       w_b_p0;

  // Stage p0: combinational encode; index forced to 0 whenever not valid.
  always_comb begin
    w_vld_p0 = en & (|a);
    w_idx_p0 = '0;
    if (w_vld_p0) begin
      w_idx_p0 = (MSB_PRIORITY != 0) ? enc_msb(a) : enc_lsb(a);
    end
    w_b_p0 = {w_vld_p0, w_idx_p0};
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [3:0] r_b_p1;

      // Stage p1: registered output, synchronous active-low clear.
      always_ff @(posedge clk) begin
        if (!rst_n) r_b_p1 <= '0;
        else        r_b_p1 <= w_b_p0;
      end

      assign b = r_b_p1;
    end else begin : g_comb
      logic w_unused_ctl;
      assign w_unused_ctl = clk ^ rst_n;
      assign b            = w_b_p0;
    end
  endgenerate

endmodule

// File: tb/tb_encoder_8x3.sv
// Bench for encoder_8x3: table-driven vectors with a scoreboard queue, covering
// registered MSB/LSB instances and a combinational instance.
module tb_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic       en;
  logic [3:0] b_msb;
  logic [3:0] b_lsb;
  logic [3:0] b_comb;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic       en;
    logic       rst_n;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] exp_msb;
    logic [3:0] exp_lsb;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  encoder_8x3 #(.MSB_PRIORITY(1), .REG_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .b(b_msb));

  encoder_8x3 #(.MSB_PRIORITY(0), .REG_OUT(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .b(b_lsb));

  encoder_8x3 #(.MSB_PRIORITY(1), .REG_OUT(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .b(b_comb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: scan from the preferred end and stop at the first set bit.
  function automatic logic [3:0] model(input logic [7:0] v, input logic e, input bit msb);
    if (!e || v == 8'h00) return 4'b0000;
    if (msb) begin
      for (int k = 7; k >= 0; k--) if (v[k]) return {1'b1, 3'(k)};
    end else begin
      for (int k = 0; k < 8; k++) if (v[k]) return {1'b1, 3'(k)};
    end
    return 4'b0000;
  endfunction

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Drive one cycle of stimulus (called #1 after a rising edge), then compare.
  task automatic step(input string nm, input logic [7:0] va, input logic ve,
                      input logic vr, input logic [3:0] exp_msb);
    sb_t e;
    a     = va;
    en    = ve;
    rst_n = vr;
    e.exp_msb = exp_msb;
    e.exp_lsb = vr ? model(va, ve, 1'b0) : 4'b0000;
    sb.push_back(e);
    #1;
    check({nm, "_comb"}, b_comb, model(va, ve, 1'b1));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: got empty expected entry", nm);
    end else begin
      e = sb.pop_front();
      check({nm, "_msb"}, b_msb, e.exp_msb);
      check({nm, "_lsb"}, b_lsb, e.exp_lsb);
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic       re;
    logic       rr;
    a = 8'h00; en = 1'b0; rst_n = 1'b0;

    // Scenario 1: reset with all requests high.
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 4'b1111});
    // Scenario 2: one-hot sweep.
    tbl.push_back('{8'h01, 1'b1, 1'b1, 4'b1000});
    tbl.push_back('{8'h02, 1'b1, 1'b1, 4'b1001});
    tbl.push_back('{8'h04, 1'b1, 1'b1, 4'b1010});
    tbl.push_back('{8'h08, 1'b1, 1'b1, 4'b1011});
    tbl.push_back('{8'h10, 1'b1, 1'b1, 4'b1100});
    tbl.push_back('{8'h20, 1'b1, 1'b1, 4'b1101});
    tbl.push_back('{8'h40, 1'b1, 1'b1, 4'b1110});
    tbl.push_back('{8'h80, 1'b1, 1'b1, 4'b1111});
    // Scenario 3: multi-hot priority.
    tbl.push_back('{8'b00011100, 1'b1, 1'b1, 4'b1100});
    tbl.push_back('{8'b10000001, 1'b1, 1'b1, 4'b1111});
    // Scenario 5: disabled.
    tbl.push_back('{8'h00, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{8'h1C, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{8'h08, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{8'h10, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{8'h20, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{8'h40, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{8'h80, 1'b0, 1'b1, 4'b0000});
    // Scenario 6: zero input, then mid-stream reset and release.
    tbl.push_back('{8'h00, 1'b1, 1'b1, 4'b0000});
    tbl.push_back('{8'h20, 1'b1, 1'b1, 4'b1101});
    tbl.push_back('{8'h20, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{8'h20, 1'b1, 1'b1, 4'b1101});

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].a, tbl[i].en, tbl[i].rst_n, tbl[i].exp);
    end

    // Reset and inputs toggled between edges must not disturb registered b.
    rst_n = 1'b0;
    a     = 8'h01;
    #2;
    check("async_rst_low", b_msb, 4'b1101);
    rst_n = 1'b1;
    #2;
    check("async_rst_high", b_msb, 4'b1101);
    @(posedge clk);
    #1;
    check("next_edge_update", b_msb, 4'b1000);

    // Scenario 4: LSB-priority instance on the same multi-hot pattern.
    step("lsb_multi", 8'b00011100, 1'b1, 1'b1, 4'b1100);
    check("lsb_multi_const", b_lsb, 4'b1010);

    // Random traffic with occasional reset.
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 8'h01 << $urandom_range(0, 7);
      re = ($urandom_range(0, 4) != 0);
      rr = ($urandom_range(0, 9) != 0);
      step($sformatf("rnd%0d", i), ra, re, rr, rr ? model(ra, re, 1'b1) : 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_8x3.md
ENCODER_8X3 -- requirements
Module: encoder_8x3

Interface
Parameters:
REQ-001 The block SHALL have parameter MSB_PRIORITY, default 1, meaning 1 = highest set index wins and 0 = lowest set index wins.
REQ-002 The block SHALL have parameter REG_OUT, default 1, meaning 1 = registered output and 0 = combinational output (reset then ignored).

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-005 The block SHALL have port a, input, 8, request lines; bit i means request i is active.
REQ-006 The block SHALL have port en, input, 1, encoder enable, active-high.
REQ-007 The block SHALL have port b, output, 4, the encoded result: b[3] = valid, b[2:0] = encoded index.
REQ-008 Port order SHALL be clk, rst_n, a, en, b.

Function
REQ-009 Valid (b[3]) SHALL equal en AND (a != 0).
REQ-010 The index with MSB_PRIORITY=1 SHALL be the position of the highest set bit of a.
REQ-011 The index with MSB_PRIORITY=0 SHALL be the position of the lowest set bit of a.
REQ-012 Multiple set bits SHALL be legal: the priority rule resolves them, with no error flag.
REQ-013 With en=0, b SHALL be 4'b0000, regardless of a.
REQ-014 With en=1 and a=0, b SHALL be 4'b0000, i.e. invalid with index 0.
REQ-015 Whenever valid=0, b[2:0] SHALL be 0; no stale index is held.
REQ-016 With REG_OUT=1, b SHALL be registered and show the encoding of the a/en values sampled at the previous rising clk edge (latency exactly 1 cycle).
REQ-017 With REG_OUT=1, b SHALL change only on rising clk edges, with no glitch path from a/en to b.
REQ-018 With REG_OUT=0, b SHALL be a purely combinational function of a and en (latency 0).
REQ-019 Any a/en change SHALL take effect on the next edge; the block has no hold or sticky behaviour.
REQ-020 Any X or Z on a or en SHALL be treated as don't-care by the design; the bench drives only 0/1.

Reset
REQ-021 When rst_n=0 is sampled at a rising clk edge, b SHALL be 4'b0000 after that edge, overriding a and en.
REQ-022 While rst_n is held low, b SHALL remain 4'b0000.
REQ-023 At the first edge with rst_n=1, b SHALL take the encoding of the current a/en.
REQ-024 Reset asserted mid-operation SHALL clear b on the same edge, and no prior result SHALL reappear after release.
REQ-025 Reset SHALL have no asynchronous effect: rst_n toggling between edges leaves b unchanged.

Verification
All scenarios below use MSB_PRIORITY=1 and REG_OUT=1; responses are checked one cycle after the stimulus.
REQ-026 Scenario 1 (reset): rst_n=0 for 2 cycles with en=1, a=8'hFF -> b=0000 throughout; rst_n=1 -> next cycle b=1111.
REQ-027 Scenario 2 (one-hot sweep): en=1, a=01h, 02h, 04h, 08h, 10h, 20h, 40h, 80h -> b=1000, 1001, 1010, 1011, 1100, 1101, 1110, 1111.
REQ-028 Scenario 3 (multi-hot priority): en=1, a=8'b00011100 -> b=1100; a=8'b10000001 -> b=1111.
REQ-029 Scenario 4 (multi-hot, MSB_PRIORITY=0 instance): a=8'b00011100 -> b=1010.
REQ-030 Scenario 5 (disable): en=0 with a=00h, 1Ch, 08h, 10h, 20h, 40h, 80h in turn -> b=0000 for every value.
REQ-031 Scenario 6 (zero input and mid-stream reset): en=1, a=00h -> b=0000. Then a=20h -> b=1101; rst_n=0 for one edge -> b=0000; release with a=20h -> b=1101 on the next cycle.
